// File: rtl/hw_mailbox_pkg.sv
// Shared types and constants for the software/hardware mailbox.
package hw_mailbox_pkg;

    localparam int unsigned N_WORDS = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEQ_W   = 6;
    localparam int unsigned IDX_W   = $clog2(N_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_CHECK,
        S_COMMIT,
        S_DONE,
        S_ERR,
        S_ABORT
    } mb_state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_REQ   = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b10;
    localparam logic [1:0] CMD_ILL   = 2'b11;

    localparam logic [1:0] RSP_IDLE  = 2'b00;
    localparam logic [1:0] RSP_DONE  = 2'b01;
    localparam logic [1:0] RSP_ERR   = 2'b10;
    localparam logic [1:0] RSP_ABORT = 2'b11;

endpackage

// File: rtl/mailbox_checksum.sv
// Rotate-left-by-one / XOR frame checksum accumulator with clear and enable.
module mailbox_checksum
    import hw_mailbox_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= {acc[DATA_W-2:0], acc[DATA_W-1]} ^ data;
        end
    end

endmodule

// File: rtl/hw_mailbox_responder.sv
// Hardware end of the Nios mailbox: captures, checksums and commits a
// 16-word frame into a double-buffered active frame, answering with a 4-phase handshake.
module hw_mailbox_responder
    import hw_mailbox_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  to_hw_sig,
    input  logic [31:0] to_hw_port0,
    input  logic [31:0] to_hw_port1,
    input  logic [31:0] to_hw_port2,
    input  logic [31:0] to_hw_port3,
    input  logic [31:0] to_hw_port4,
    input  logic [31:0] to_hw_port5,
    input  logic [31:0] to_hw_port6,
    input  logic [31:0] to_hw_port7,
    input  logic [31:0] to_hw_port8,
    input  logic [31:0] to_hw_port9,
    input  logic [31:0] to_hw_port10,
    input  logic [31:0] to_hw_port11,
    input  logic [31:0] to_hw_port12,
    input  logic [31:0] to_hw_port13,
    input  logic [31:0] to_hw_port14,
    input  logic [31:0] to_hw_port15,
    output logic [1:0]  to_sw_sig,
    output logic [31:0] to_sw_port0,
    output logic [31:0] to_sw_port1,
    output logic [7:0]  to_sw_port2,
    input  logic [31:0] game_status,
    input  logic [3:0]  frame_rd_addr,
    output logic [31:0] frame_rd_data,
    output logic        frame_valid,
    input  logic        frame_busy
);

    mb_state_t         state;
    logic [1:0]        sig_q;
    logic [IDX_W-1:0]  idx;
    logic [SEQ_W-1:0]  seq;
    logic              err;
    logic              ovf;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] hw_words [N_WORDS];
    logic [DATA_W-1:0] shadow   [N_WORDS];
    logic [DATA_W-1:0] active   [N_WORDS];

    assign hw_words[0]  = to_hw_port0;
    assign hw_words[1]  = to_hw_port1;
    assign hw_words[2]  = to_hw_port2;
    assign hw_words[3]  = to_hw_port3;
    assign hw_words[4]  = to_hw_port4;
    assign hw_words[5]  = to_hw_port5;
    assign hw_words[6]  = to_hw_port6;
    assign hw_words[7]  = to_hw_port7;
    assign hw_words[8]  = to_hw_port8;
    assign hw_words[9]  = to_hw_port9;
    assign hw_words[10] = to_hw_port10;
    assign hw_words[11] = to_hw_port11;
    assign hw_words[12] = to_hw_port12;
    assign hw_words[13] = to_hw_port13;
    assign hw_words[14] = to_hw_port14;
    assign hw_words[15] = to_hw_port15;

    assign to_sw_port2   = {seq, err, ovf};
    assign frame_rd_data = active[frame_rd_addr];

    mailbox_checksum u_checksum (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == S_CAPTURE),
        .enable ((state == S_CHECK) && (sig_q == CMD_REQ)),
        .data   (shadow[idx]),
        .acc    (acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            sig_q       <= CMD_IDLE;
            idx         <= '0;
            seq         <= '0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            to_sw_sig   <= RSP_IDLE;
            to_sw_port0 <= '0;
            to_sw_port1 <= '0;
            frame_valid <= 1'b0;
            for (int unsigned i = 0; i < N_WORDS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            sig_q       <= to_hw_sig;
            frame_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    case (sig_q)
                        CMD_REQ:   state <= S_CAPTURE;
                        CMD_ILL:   state <= S_ERR;
                        CMD_ABORT: state <= S_ABORT;
                        default:   state <= S_IDLE;
                    endcase
                end
                S_CAPTURE: begin
                    for (int unsigned i = 0; i < N_WORDS; i++) shadow[i] <= hw_words[i];
                    idx   <= '0;
                    state <= (sig_q == CMD_ABORT) ? S_ABORT : S_CHECK;
                end
                S_CHECK: begin
                    if (sig_q == CMD_ABORT) begin
                        state <= S_ABORT;
                    end else if (sig_q != CMD_REQ) begin
                        state <= S_ERR;
                    end else begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(N_WORDS - 1)) state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    for (int unsigned i = 0; i < N_WORDS; i++) active[i] <= shadow[i];
                    frame_valid <= 1'b1;
                    to_sw_port0 <= game_status;
                    to_sw_port1 <= acc;
                    seq         <= seq + 1'b1;
                    ovf         <= frame_busy;
                    err         <= 1'b0;
                    state       <= S_DONE;
                end
                // Each response is shown for at least one cycle before it may be withdrawn.
                S_DONE: begin
                    if (to_sw_sig == RSP_DONE && (sig_q == CMD_IDLE || sig_q == CMD_ABORT)) begin
                        to_sw_sig <= RSP_IDLE;
                        state     <= S_IDLE;
                    end else begin
                        to_sw_sig <= RSP_DONE;
                    end
                end
                S_ERR: begin
                    err <= 1'b1;
                    if (to_sw_sig == RSP_ERR && sig_q == CMD_IDLE) begin
                        to_sw_sig <= RSP_IDLE;
                        state     <= S_IDLE;
                    end else begin
                        to_sw_sig <= RSP_ERR;
                    end
                end
                S_ABORT: begin
                    if (to_sw_sig == RSP_ABORT && sig_q == CMD_IDLE) begin
                        to_sw_sig <= RSP_IDLE;
                        state     <= S_IDLE;
                    end else begin
                        to_sw_sig <= RSP_ABORT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hw_mailbox_responder.sv
// Directed bench for hw_mailbox_responder with hand-computed expected values.
module tb_hw_mailbox_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  to_hw_sig;
    logic [31:0] words [16];
    logic [1:0]  to_sw_sig;
    logic [31:0] to_sw_port0;
    logic [31:0] to_sw_port1;
    logic [7:0]  to_sw_port2;
    logic [31:0] game_status;
    logic [3:0]  frame_rd_addr;
    logic [31:0] frame_rd_data;
    logic        frame_valid;
    logic        frame_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hw_mailbox_responder dut (
        .clk           (clk),
        .reset         (reset),
        .to_hw_sig     (to_hw_sig),
        .to_hw_port0   (words[0]),
        .to_hw_port1   (words[1]),
        .to_hw_port2   (words[2]),
        .to_hw_port3   (words[3]),
        .to_hw_port4   (words[4]),
        .to_hw_port5   (words[5]),
        .to_hw_port6   (words[6]),
        .to_hw_port7   (words[7]),
        .to_hw_port8   (words[8]),
        .to_hw_port9   (words[9]),
        .to_hw_port10  (words[10]),
        .to_hw_port11  (words[11]),
        .to_hw_port12  (words[12]),
        .to_hw_port13  (words[13]),
        .to_hw_port14  (words[14]),
        .to_hw_port15  (words[15]),
        .to_sw_sig     (to_sw_sig),
        .to_sw_port0   (to_sw_port0),
        .to_sw_port1   (to_sw_port1),
        .to_sw_port2   (to_sw_port2),
        .game_status   (game_status),
        .frame_rd_addr (frame_rd_addr),
        .frame_rd_data (frame_rd_data),
        .frame_valid   (frame_valid),
        .frame_busy    (frame_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input logic [31:0] fill);
        for (int i = 0; i < 16; i++) words[i] = fill;
    endtask

    // k = 0 is the first rising edge after the stimulus; returns -1 on timeout.
    task automatic wait_rsp(input logic [1:0] want, output int cycles, output int pulses);
        cycles = -1;
        pulses = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) pulses++;
            if (to_sw_sig == want) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic do_commit(output int lat, output int pulses, output int rel);
        int p1, p2;
        @(negedge clk);
        to_hw_sig = 2'b01;
        wait_rsp(2'b01, lat, p1);
        @(negedge clk);
        to_hw_sig = 2'b00;
        wait_rsp(2'b00, rel, p2);
        pulses = p1 + p2;
    endtask

    task automatic read_frame(input logic [3:0] addr, output logic [31:0] data);
        frame_rd_addr = addr;
        #1;
        data = frame_rd_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses, rel, c, p, bad;
        logic [31:0] rd;

        reset = 1'b1;
        to_hw_sig = 2'b00;
        set_frame(32'h0);
        game_status = 32'h0;
        frame_rd_addr = 4'd0;
        frame_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sig",   32'(to_sw_sig), 32'h0);
        check_eq("rst_port0", to_sw_port0, 32'h0);
        check_eq("rst_port1", to_sw_port1, 32'h0);
        check_eq("rst_port2", 32'(to_sw_port2), 32'h0);
        check_eq("rst_valid", 32'(frame_valid), 32'h0);
        check_eq("rst_rd0",   frame_rd_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single-bit frame: bit 0 is rotated 15 more times -> 0x8000.
        set_frame(32'h0);
        words[0] = 32'h0000_0001;
        game_status = 32'h0000_0ABC;
        do_commit(lat, pulses, rel);
        check_eq("c1_latency", 32'(lat), 32'd20);
        check_eq("c1_pulses",  32'(pulses), 32'd1);
        check_eq("c1_release", 32'(rel >= 0), 32'd1);
        check_eq("c1_port0",   to_sw_port0, 32'h0000_0ABC);
        check_eq("c1_port1",   to_sw_port1, 32'h0000_8000);
        check_eq("c1_port2",   32'(to_sw_port2), 32'h04);
        read_frame(4'd0, rd);
        check_eq("c1_rd0", rd, 32'h0000_0001);
        read_frame(4'd1, rd);
        check_eq("c1_rd1", rd, 32'h0);

        // All-ones frame cancels in pairs; frame_busy reported as ovf.
        set_frame(32'hFFFF_FFFF);
        game_status = 32'hCAFE_F00D;
        frame_busy = 1'b1;
        do_commit(lat, pulses, rel);
        frame_busy = 1'b0;
        check_eq("c2_latency", 32'(lat), 32'd20);
        check_eq("c2_pulses",  32'(pulses), 32'd1);
        check_eq("c2_port0",   to_sw_port0, 32'hCAFE_F00D);
        check_eq("c2_port1",   to_sw_port1, 32'h0);
        check_eq("c2_port2",   32'(to_sw_port2), 32'h09);
        read_frame(4'd9, rd);
        check_eq("c2_rd9", rd, 32'hFFFF_FFFF);

        // Abort part way through CHECK: nothing committed, seq untouched.
        set_frame(32'h5555_5555);
        @(negedge clk);
        to_hw_sig = 2'b01;
        repeat (10) @(posedge clk);
        @(negedge clk);
        to_hw_sig = 2'b10;
        wait_rsp(2'b11, c, p);
        check_eq("ab_rsp",    32'(c >= 0), 32'd1);
        check_eq("ab_pulses", 32'(p), 32'd0);
        read_frame(4'd0, rd);
        check_eq("ab_rd0",    rd, 32'hFFFF_FFFF);
        check_eq("ab_port2",  32'(to_sw_port2), 32'h09);
        check_eq("ab_port1",  to_sw_port1, 32'h0);
        @(negedge clk);
        to_hw_sig = 2'b00;
        wait_rsp(2'b00, c, p);
        check_eq("ab_release", 32'(c >= 0), 32'd1);

        // Illegal command from IDLE raises err.
        @(negedge clk);
        to_hw_sig = 2'b11;
        wait_rsp(2'b10, c, p);
        check_eq("il_rsp",   32'(c >= 0), 32'd1);
        check_eq("il_port2", 32'(to_sw_port2), 32'h0B);
        @(negedge clk);
        to_hw_sig = 2'b00;
        wait_rsp(2'b00, c, p);
        check_eq("il_release", 32'(c >= 0), 32'd1);
        check_eq("il_hold",    32'(to_sw_port2), 32'h0B);

        // 0x80000000 rotated 15 times is 0x4000, xored with the last word.
        set_frame(32'h0);
        words[0]  = 32'h8000_0000;
        words[15] = 32'h1234_5678;
        do_commit(lat, pulses, rel);
        check_eq("c3_latency", 32'(lat), 32'd20);
        check_eq("c3_port1",   to_sw_port1, 32'h1234_1678);
        check_eq("c3_port2",   32'(to_sw_port2), 32'h0C);
        read_frame(4'd15, rd);
        check_eq("c3_rd15", rd, 32'h1234_5678);
        read_frame(4'd0, rd);
        check_eq("c3_rd0", rd, 32'h8000_0000);
        read_frame(4'd7, rd);
        check_eq("c3_rd7", rd, 32'h0);

        // Sequence counter: 3 + 60 = 63, one more wraps to 0.
        bad = 0;
        for (int n = 0; n < 60; n++) begin
            set_frame(32'(n));
            do_commit(lat, pulses, rel);
            if (lat != 20 || pulses != 1 || rel < 0) bad++;
        end
        check_eq("wr_bad",    32'(bad), 32'd0);
        check_eq("wr_seq63",  32'(to_sw_port2), 32'hFC);
        do_commit(lat, pulses, rel);
        check_eq("wr_seq0",   32'(to_sw_port2), 32'h00);
        check_eq("wr_latency", 32'(lat), 32'd20);

        // Asynchronous reset in the middle of CHECK.
        set_frame(32'h1111_1111);
        frame_rd_addr = 4'd3;
        @(negedge clk);
        to_hw_sig = 2'b01;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mr_sig",   32'(to_sw_sig), 32'h0);
        check_eq("mr_port0", to_sw_port0, 32'h0);
        check_eq("mr_port1", to_sw_port1, 32'h0);
        check_eq("mr_port2", 32'(to_sw_port2), 32'h0);
        check_eq("mr_valid", 32'(frame_valid), 32'h0);
        check_eq("mr_rd3",   frame_rd_data, 32'h0);
        to_hw_sig = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check_eq("mr_idle_sig", 32'(to_sw_sig), 32'h0);
        check_eq("mr_idle_rd3", frame_rd_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
